// File: rtl/msrv32_wb_stage_if.sv
// Write-back stage port bundle: stage-1 results and data-memory response in,
// register-file write port and pipeline stall out.
interface msrv32_wb_stage_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] rd_addr_in;
    logic                  rf_wr_en_in;
    logic [2:0]            wb_mux_sel_in;
    logic [1:0]            load_size_in;
    logic                  load_unsigned_in;
    logic [WIDTH-1:0]      alu_result_in;
    logic [WIDTH-1:0]      imm_in;
    logic [WIDTH-1:0]      pc_plus_4_in;
    logic [WIDTH-1:0]      csr_data_in;
    logic                  flush_in;
    logic [WIDTH-1:0]      dmdata_in;
    logic                  hready_in;
    logic [ADDR_WIDTH-1:0] rd_addr_out;
    logic [WIDTH-1:0]      rd_out;
    logic                  wr_en_out;
    logic                  stall_out;

    modport master (
        output rd_addr_in, rf_wr_en_in, wb_mux_sel_in, load_size_in, load_unsigned_in,
               alu_result_in, imm_in, pc_plus_4_in, csr_data_in, flush_in,
               dmdata_in, hready_in,
        input  rd_addr_out, rd_out, wr_en_out, stall_out
    );

    modport slave (
        input  rd_addr_in, rf_wr_en_in, wb_mux_sel_in, load_size_in, load_unsigned_in,
               alu_result_in, imm_in, pc_plus_4_in, csr_data_in, flush_in,
               dmdata_in, hready_in,
        output rd_addr_out, rd_out, wr_en_out, stall_out
    );
endinterface

// File: rtl/msrv32_wb_stage.sv
// Write-back stage: stage-2 pipeline register, load alignment/extension, write-back
// source select and a load-wait FSM that stalls the pipe until data memory responds.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal flow; stage-2 register captures every cycle unless stalled
// WAIT_MEM | held load is waiting for hready_in; register frozen
module msrv32_wb_stage #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic              msrv32_mp_clk_in,
    input logic              msrv32_mp_rst_in,
    msrv32_wb_stage_if.slave wb
);
    localparam logic [2:0] SEL_ALU  = 3'd0;
    localparam logic [2:0] SEL_LOAD = 3'd1;
    localparam logic [2:0] SEL_IMM  = 3'd2;
    localparam logic [2:0] SEL_PC4  = 3'd3;
    localparam logic [2:0] SEL_CSR  = 3'd4;

    typedef enum logic {
        ST_RUN,
        ST_WAIT_MEM
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [2:0]            mux_sel_q, mux_sel_d;
    logic [1:0]            load_size_q, load_size_d;
    logic                  load_unsigned_q, load_unsigned_d;
    logic [WIDTH-1:0]      alu_result_q, alu_result_d;
    logic [WIDTH-1:0]      imm_q, imm_d;
    logic [WIDTH-1:0]      pc_plus_4_q, pc_plus_4_d;
    logic [WIDTH-1:0]      csr_data_q, csr_data_d;

    logic                  held_load;
    logic                  stall;
    logic [1:0]            byte_off;
    logic [7:0]            load_byte;
    logic [15:0]           load_half;
    logic [WIDTH-1:0]      load_data;
    logic [WIDTH-1:0]      rd_data;

    assign held_load = wr_en_q && (mux_sel_q == SEL_LOAD);
    assign stall     = held_load && !wb.hready_in;

    // Stage-2 capture; a flush turns the captured slot into an all-zero bubble.
    always_comb begin
        rd_addr_d       = rd_addr_q;
        wr_en_d         = wr_en_q;
        mux_sel_d       = mux_sel_q;
        load_size_d     = load_size_q;
        load_unsigned_d = load_unsigned_q;
        alu_result_d    = alu_result_q;
        imm_d           = imm_q;
        pc_plus_4_d     = pc_plus_4_q;
        csr_data_d      = csr_data_q;
        if (!stall) begin
            if (wb.flush_in) begin
                rd_addr_d       = '0;
                wr_en_d         = 1'b0;
                mux_sel_d       = SEL_ALU;
                load_size_d     = '0;
                load_unsigned_d = 1'b0;
                alu_result_d    = '0;
                imm_d           = '0;
                pc_plus_4_d     = '0;
                csr_data_d      = '0;
            end else begin
                rd_addr_d       = wb.rd_addr_in;
                wr_en_d         = wb.rf_wr_en_in;
                mux_sel_d       = wb.wb_mux_sel_in;
                load_size_d     = wb.load_size_in;
                load_unsigned_d = wb.load_unsigned_in;
                alu_result_d    = wb.alu_result_in;
                imm_d           = wb.imm_in;
                pc_plus_4_d     = wb.pc_plus_4_in;
                csr_data_d      = wb.csr_data_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:      if (held_load && !wb.hready_in) state_d = ST_WAIT_MEM;
            ST_WAIT_MEM: if (wb.hready_in)               state_d = ST_RUN;
            default:                                     state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_in) begin
        if (!msrv32_mp_rst_in) begin
            state_q         <= ST_RUN;
            rd_addr_q       <= '0;
            wr_en_q         <= 1'b0;
            mux_sel_q       <= SEL_ALU;
            load_size_q     <= '0;
            load_unsigned_q <= 1'b0;
            alu_result_q    <= '0;
            imm_q           <= '0;
            pc_plus_4_q     <= '0;
            csr_data_q      <= '0;
        end else begin
            state_q         <= state_d;
            rd_addr_q       <= rd_addr_d;
            wr_en_q         <= wr_en_d;
            mux_sel_q       <= mux_sel_d;
            load_size_q     <= load_size_d;
            load_unsigned_q <= load_unsigned_d;
            alu_result_q    <= alu_result_d;
            imm_q           <= imm_d;
            pc_plus_4_q     <= pc_plus_4_d;
            csr_data_q      <= csr_data_d;
        end
    end

    // Halfword offset bit 0 is ignored: misaligned halves never reach this stage.
    always_comb begin
        byte_off  = alu_result_q[1:0];
        load_byte = wb.dmdata_in[{byte_off, 3'b000} +: 8];
        load_half = wb.dmdata_in[{byte_off[1], 4'b0000} +: 16];
        load_data = wb.dmdata_in;
        if (load_size_q[1] == 1'b0) begin
            if (load_size_q[0] == 1'b0) begin
                load_data = load_unsigned_q ? {{(WIDTH-8){1'b0}}, load_byte}
                                            : {{(WIDTH-8){load_byte[7]}}, load_byte};
            end else begin
                load_data = load_unsigned_q ? {{(WIDTH-16){1'b0}}, load_half}
                                            : {{(WIDTH-16){load_half[15]}}, load_half};
            end
        end
    end

    always_comb begin
        rd_data = alu_result_q;
        case (mux_sel_q)
            SEL_LOAD: rd_data = load_data;
            SEL_IMM:  rd_data = imm_q;
            SEL_PC4:  rd_data = pc_plus_4_q;
            SEL_CSR:  rd_data = csr_data_q;
            default:  rd_data = alu_result_q;
        endcase
    end

    assign wb.rd_addr_out = rd_addr_q;
    assign wb.rd_out      = rd_data;
    assign wb.stall_out   = stall;
    assign wb.wr_en_out   = wr_en_q && (rd_addr_q != '0) && !stall;

endmodule

// File: tb/tb_msrv32_wb_stage.sv
// Scoreboard bench for msrv32_wb_stage: stimulus queues expected register-file writes,
// a negedge monitor pops and compares each write the DUT issues.
module tb_msrv32_wb_stage;
    logic clk;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;
    logic [36:0] exp_q[$];

    msrv32_wb_stage_if #(.WIDTH(32), .ADDR_WIDTH(5)) bus ();

    msrv32_wb_stage #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
        .msrv32_mp_clk_in (clk),
        .msrv32_mp_rst_in (rst_b),
        .wb               (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_instr(input logic [2:0] sel, input logic [4:0] rd, input logic wen,
                             input logic [1:0] size, input logic uns, input logic [31:0] alu,
                             input logic [31:0] imm, input logic [31:0] pc4,
                             input logic [31:0] csr, input logic fl);
        bus.wb_mux_sel_in    = sel;
        bus.rd_addr_in       = rd;
        bus.rf_wr_en_in      = wen;
        bus.load_size_in     = size;
        bus.load_unsigned_in = uns;
        bus.alu_result_in    = alu;
        bus.imm_in           = imm;
        bus.pc_plus_4_in     = pc4;
        bus.csr_data_in      = csr;
        bus.flush_in         = fl;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back({rd, data});
    endtask

    // Monitor: every issued write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.wr_en_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: actual rd=%0d data=0x%08h required=no write",
                         bus.rd_addr_out, bus.rd_out);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({bus.rd_addr_out, bus.rd_out} !== e) begin
                    errors++;
                    $display("FAIL write: actual rd=%0d data=0x%08h required rd=%0d data=0x%08h",
                             bus.rd_addr_out, bus.rd_out, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        rst_b         = 1'b0;
        bus.hready_in = 1'b1;
        bus.dmdata_in = 32'h0;
        set_instr(3'd0, 5'd0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

        // Reset and bubbles
        repeat (2) tick();
        chk("reset_wr_en", {31'b0, bus.wr_en_out}, 32'h0);
        chk("reset_stall", {31'b0, bus.stall_out}, 32'h0);
        chk("reset_rd_out", bus.rd_out, 32'h0);
        rst_b = 1'b1;
        repeat (3) tick();
        chk("bubble_wr_en", {31'b0, bus.wr_en_out}, 32'h0);

        // ALU write
        set_instr(3'd0, 5'd5, 1'b1, 2'd0, 1'b0, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_wr(5'd5, 32'h1234_5678);
        tick();
        chk("alu_wr_en", {31'b0, bus.wr_en_out}, 32'h1);
        chk("alu_rd_addr", {27'b0, bus.rd_addr_out}, 32'd5);
        chk("alu_rd_out", bus.rd_out, 32'h1234_5678);

        // Load alignment, data ready immediately
        bus.dmdata_in = 32'h80AA_BB11;
        set_instr(3'd1, 5'd8, 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_wr(5'd8, 32'hFFFF_FF80);
        tick();
        chk("lb_rd_out", bus.rd_out, 32'hFFFF_FF80);
        set_instr(3'd1, 5'd9, 1'b1, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_wr(5'd9, 32'h0000_0080);
        tick();
        set_instr(3'd1, 5'd10, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_wr(5'd10, 32'hFFFF_80AA);
        tick();
        chk("lh_stall", {31'b0, bus.stall_out}, 32'h0);
        set_instr(3'd1, 5'd11, 1'b1, 2'b01, 1'b1, 32'h0000_0000, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_wr(5'd11, 32'h0000_BB11);
        tick();
        set_instr(3'd1, 5'd20, 1'b1, 2'b11, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_wr(5'd20, 32'h80AA_BB11);
        tick();

        // LW waiting two cycles on data memory
        set_instr(3'd1, 5'd7, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_wr(5'd7, 32'hDEAD_BEEF);
        tick();
        bus.hready_in = 1'b0;
        bus.dmdata_in = 32'h0;
        set_instr(3'd0, 5'd12, 1'b1, 2'b00, 1'b0, 32'h0000_CAFE, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_wr(5'd12, 32'h0000_CAFE);
        #1;
        chk("lw_stall_c1", {31'b0, bus.stall_out}, 32'h1);
        chk("lw_wr_en_c1", {31'b0, bus.wr_en_out}, 32'h0);
        tick();
        chk("lw_stall_c2", {31'b0, bus.stall_out}, 32'h1);
        chk("lw_wr_en_c2", {31'b0, bus.wr_en_out}, 32'h0);
        chk("lw_held_rd", {27'b0, bus.rd_addr_out}, 32'd7);
        bus.hready_in = 1'b1;
        bus.dmdata_in = 32'hDEAD_BEEF;
        #1;
        chk("lw_done_stall", {31'b0, bus.stall_out}, 32'h0);
        chk("lw_done_wr_en", {31'b0, bus.wr_en_out}, 32'h1);
        chk("lw_done_rd_out", bus.rd_out, 32'hDEAD_BEEF);
        tick();
        chk("after_lw_rd", {27'b0, bus.rd_addr_out}, 32'd12);
        chk("after_lw_data", bus.rd_out, 32'h0000_CAFE);

        // Flush at capture, and flush held off during a stall
        set_instr(3'd0, 5'd3, 1'b1, 2'b00, 1'b0, 32'h0000_0333, 32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("flush_wr_en", {31'b0, bus.wr_en_out}, 32'h0);
        set_instr(3'd1, 5'd13, 1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_wr(5'd13, 32'h1122_3344);
        tick();
        bus.hready_in = 1'b0;
        set_instr(3'd0, 5'd14, 1'b1, 2'b00, 1'b0, 32'h0000_0444, 32'h0, 32'h0, 32'h0, 1'b1);
        #1;
        chk("flush_stall_c1", {31'b0, bus.stall_out}, 32'h1);
        tick();
        chk("flush_stall_c2", {31'b0, bus.stall_out}, 32'h1);
        chk("flush_held_rd", {27'b0, bus.rd_addr_out}, 32'd13);
        bus.hready_in = 1'b1;
        bus.dmdata_in = 32'h1122_3344;
        tick();
        chk("flush_late_wr_en", {31'b0, bus.wr_en_out}, 32'h0);
        set_instr(3'd0, 5'd15, 1'b1, 2'b00, 1'b0, 32'h0000_0055, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_wr(5'd15, 32'h0000_0055);
        tick();
        chk("post_flush_wr_en", {31'b0, bus.wr_en_out}, 32'h1);

        // x0 destination, other sources
        set_instr(3'd3, 5'd0, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0000_0100, 32'h0, 1'b0);
        tick();
        chk("x0_wr_en", {31'b0, bus.wr_en_out}, 32'h0);
        set_instr(3'd4, 5'd16, 1'b1, 2'b00, 1'b0, 32'h1, 32'h2, 32'h3, 32'h0000_C5C5, 1'b0);
        expect_wr(5'd16, 32'h0000_C5C5);
        tick();
        set_instr(3'd2, 5'd17, 1'b1, 2'b00, 1'b0, 32'h1, 32'hABCD_E000, 32'h3, 32'h4, 1'b0);
        expect_wr(5'd17, 32'hABCD_E000);
        tick();
        set_instr(3'd6, 5'd18, 1'b1, 2'b00, 1'b0, 32'h0000_6666, 32'h2, 32'h3, 32'h4, 1'b0);
        expect_wr(5'd18, 32'h0000_6666);
        tick();
        set_instr(3'd3, 5'd21, 1'b1, 2'b00, 1'b0, 32'h1, 32'h2, 32'h0000_0204, 32'h4, 1'b0);
        expect_wr(5'd21, 32'h0000_0204);
        tick();

        // Reset asserted while a load waits on memory
        set_instr(3'd1, 5'd19, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        bus.hready_in = 1'b0;
        set_instr(3'd0, 5'd0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("rst_pre_stall", {31'b0, bus.stall_out}, 32'h1);
        rst_b = 1'b0;
        #1;
        chk("rst_stall", {31'b0, bus.stall_out}, 32'h0);
        chk("rst_wr_en", {31'b0, bus.wr_en_out}, 32'h0);
        chk("rst_rd_out", bus.rd_out, 32'h0);
        tick();
        rst_b = 1'b1;
        bus.hready_in = 1'b1;
        repeat (3) tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_writes: actual=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
